// File: rtl/trace_event_sequencer_if.sv
// Event-in / capture-out bundle for trace_event_sequencer.
// Counter outputs exist only when TRACE_SEQ_COUNTERS_EN is defined.
interface trace_event_sequencer_if #(
  parameter int PAYLOAD_WIDTH = 608
);
  logic                     wb_en;
  logic [1:0]               wb_pipe;
  logic                     wb_is_vector;
  logic [PAYLOAD_WIDTH-1:0] wb_payload;
  logic                     st_en;
  logic [PAYLOAD_WIDTH-1:0] st_payload;
  logic                     pcd_en;
  logic                     pcd_late;
  logic [PAYLOAD_WIDTH-1:0] pcd_payload;
  logic                     cancel_en;
  logic                     out_valid;
  logic [1:0]               out_type;
  logic [PAYLOAD_WIDTH-1:0] out_payload;
  logic                     collision_err;
`ifdef TRACE_SEQ_COUNTERS_EN
  logic [31:0]              emitted_count;
  logic [31:0]              cancelled_count;
`endif

  modport master (
    output wb_en, wb_pipe, wb_is_vector, wb_payload,
    output st_en, st_payload,
    output pcd_en, pcd_late, pcd_payload,
    output cancel_en,
    input  out_valid, out_type, out_payload, collision_err
`ifdef TRACE_SEQ_COUNTERS_EN
    , input emitted_count, cancelled_count
`endif
  );

  modport slave (
    input  wb_en, wb_pipe, wb_is_vector, wb_payload,
    input  st_en, st_payload,
    input  pcd_en, pcd_late, pcd_payload,
    input  cancel_en,
    output out_valid, out_type, out_payload, collision_err
`ifdef TRACE_SEQ_COUNTERS_EN
    , output emitted_count, cancelled_count
`endif
  );
endinterface

// File: rtl/trace_event_sequencer.sv
// Shift-queue reorder buffer restoring issue order of out-of-order retire events.
// Optional emitted/cancelled counters are built when TRACE_SEQ_COUNTERS_EN is defined.
module trace_event_sequencer #(
  parameter int QUEUE_LEN     = 7,
  parameter int PAYLOAD_WIDTH = 608,
  parameter int SLOT_MULTI    = 0,
  parameter int SLOT_MEM      = 3,
  parameter int SLOT_ARITH    = 4,
  parameter int SLOT_STORE    = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  trace_event_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    EV_INVALID = 2'd0,
    EV_SWB     = 2'd1,
    EV_VWB     = 2'd2,
    EV_STORE   = 2'd3
  } ev_type_e;

  if (QUEUE_LEN < 2) begin : g_bad_len
    $error("trace_event_sequencer: QUEUE_LEN must be >= 2");
  end
  if (SLOT_MULTI >= QUEUE_LEN || SLOT_MEM >= QUEUE_LEN ||
      SLOT_ARITH >= QUEUE_LEN || SLOT_STORE >= QUEUE_LEN) begin : g_bad_slot
    $error("trace_event_sequencer: insert slot outside queue");
  end

  function automatic ev_type_e wb_type(input logic is_vector);
    return is_vector ? EV_VWB : EV_SWB;
  endfunction

  logic                     slot_vld  [QUEUE_LEN];
  ev_type_e                 slot_type [QUEUE_LEN];
  logic [PAYLOAD_WIDTH-1:0] slot_pay  [QUEUE_LEN];
  logic                     nxt_vld   [QUEUE_LEN];
  ev_type_e                 nxt_type  [QUEUE_LEN];
  logic [PAYLOAD_WIDTH-1:0] nxt_pay   [QUEUE_LEN];
  logic [QUEUE_LEN-1:0]     st_req;
  logic [QUEUE_LEN-1:0]     pcd_req;
  logic [QUEUE_LEN-1:0]     wb_req;
  logic                     coll_nxt;
  logic                     cancel_hit;
  logic                     collision_q;

  // Shift, then insert in ascending priority (st, pcd, wb) so the strongest writer lands last.
  always_comb begin
    st_req     = '0;
    pcd_req    = '0;
    wb_req     = '0;
    coll_nxt   = 1'b0;
    cancel_hit = 1'b0;
    for (int i = 0; i < QUEUE_LEN - 1; i++) begin
      nxt_vld[i]  = slot_vld[i+1];
      nxt_type[i] = slot_type[i+1];
      nxt_pay[i]  = slot_pay[i+1];
    end
    nxt_vld[QUEUE_LEN-1]  = 1'b0;
    nxt_type[QUEUE_LEN-1] = EV_INVALID;
    nxt_pay[QUEUE_LEN-1]  = '0;

    if (bus.st_en) st_req[SLOT_STORE] = 1'b1;
    if (bus.pcd_en) begin
      if (bus.pcd_late) pcd_req[SLOT_ARITH] = 1'b1;
      else              pcd_req[SLOT_STORE] = 1'b1;
    end
    if (bus.wb_en) begin
      case (bus.wb_pipe)
        2'd0:    wb_req[SLOT_MULTI] = 1'b1;
        2'd1:    wb_req[SLOT_MEM]   = 1'b1;
        2'd2:    wb_req[SLOT_ARITH] = 1'b1;
        default: coll_nxt           = 1'b1;
      endcase
    end

    for (int i = 0; i < QUEUE_LEN; i++) begin
      if (st_req[i]) begin
        coll_nxt    = coll_nxt | nxt_vld[i];
        nxt_vld[i]  = 1'b1;
        nxt_type[i] = EV_STORE;
        nxt_pay[i]  = bus.st_payload;
      end
      if (pcd_req[i]) begin
        coll_nxt    = coll_nxt | nxt_vld[i];
        nxt_vld[i]  = 1'b1;
        nxt_type[i] = EV_SWB;
        nxt_pay[i]  = bus.pcd_payload;
      end
      if (wb_req[i]) begin
        coll_nxt    = coll_nxt | nxt_vld[i];
        nxt_vld[i]  = 1'b1;
        nxt_type[i] = wb_type(bus.wb_is_vector);
        nxt_pay[i]  = bus.wb_payload;
      end
    end

    if (bus.cancel_en) begin
      cancel_hit          = nxt_vld[SLOT_ARITH];
      nxt_vld[SLOT_ARITH] = 1'b0;
    end

    // Invalid slots carry zero so slot 0 can drive out_payload straight from its register.
    for (int i = 0; i < QUEUE_LEN; i++) begin
      if (!nxt_vld[i]) begin
        nxt_type[i] = EV_INVALID;
        nxt_pay[i]  = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < QUEUE_LEN; i++) begin
        slot_vld[i]  <= 1'b0;
        slot_type[i] <= EV_INVALID;
        slot_pay[i]  <= '0;
      end
      collision_q <= 1'b0;
    end else begin
      for (int i = 0; i < QUEUE_LEN; i++) begin
        slot_vld[i]  <= nxt_vld[i];
        slot_type[i] <= nxt_type[i];
        slot_pay[i]  <= nxt_pay[i];
      end
      collision_q <= collision_q | coll_nxt;
    end
  end

  assign bus.out_valid     = slot_vld[0];
  assign bus.out_type      = slot_type[0];
  assign bus.out_payload   = slot_pay[0];
  assign bus.collision_err = collision_q;

`ifdef TRACE_SEQ_COUNTERS_EN
  logic [31:0] emitted_q;
  logic [31:0] cancelled_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      emitted_q   <= '0;
      cancelled_q <= '0;
    end else begin
      emitted_q   <= emitted_q + 32'(nxt_vld[0]);
      cancelled_q <= cancelled_q + 32'(cancel_hit);
    end
  end

  assign bus.emitted_count   = emitted_q;
  assign bus.cancelled_count = cancelled_q;
`endif

endmodule

// File: tb/tb_trace_event_sequencer.sv
// Randomized and directed bench for trace_event_sequencer against a time-slot schedule model.
module tb_trace_event_sequencer;
  localparam int PW   = 608;
  localparam int SMUL = 0;
  localparam int SMEM = 3;
  localparam int SAR  = 4;
  localparam int SST  = 5;
  localparam int HZ   = 16;

  logic clk;
  logic reset;
  trace_event_sequencer_if #(.PAYLOAD_WIDTH(PW)) bus ();

  trace_event_sequencer #(.PAYLOAD_WIDTH(PW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_on = 0;

  // Model: each event is booked for the absolute edge at which it must appear.
  int unsigned now = 0;
  bit          sv   [HZ];
  bit [1:0]    sty  [HZ];
  logic [PW-1:0] spay [HZ];
  bit          exp_valid;
  bit [1:0]    exp_type;
  logic [PW-1:0] exp_pay;
  bit          exp_coll;
  logic [31:0] exp_em;
  logic [31:0] exp_can;

  logic [PW-1:0] seen_pay [$];
  logic [1:0]    seen_ty  [$];
  int            seen_edge[$];

  task automatic check(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, want);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < HZ; i++) begin
      sv[i] = 0; sty[i] = 0; spay[i] = '0;
    end
    exp_valid = 0; exp_type = 0; exp_pay = '0; exp_coll = 0;
    exp_em = 0; exp_can = 0;
  endtask

  task automatic book(input int k, input bit [1:0] ty, input logic [PW-1:0] p, inout bit coll);
    int idx;
    idx = int'((now + k) % HZ);
    if (sv[idx]) coll = 1;
    sv[idx] = 1; sty[idx] = ty; spay[idx] = p;
  endtask

  task automatic model_edge();
    bit coll;
    int idx;
    coll = 0;
    if (bus.st_en) book(SST, 2'd3, bus.st_payload, coll);
    if (bus.pcd_en) book(bus.pcd_late ? SAR : SST, 2'd1, bus.pcd_payload, coll);
    if (bus.wb_en) begin
      case (bus.wb_pipe)
        2'd0: book(SMUL, bus.wb_is_vector ? 2'd2 : 2'd1, bus.wb_payload, coll);
        2'd1: book(SMEM, bus.wb_is_vector ? 2'd2 : 2'd1, bus.wb_payload, coll);
        2'd2: book(SAR,  bus.wb_is_vector ? 2'd2 : 2'd1, bus.wb_payload, coll);
        default: coll = 1;
      endcase
    end
    if (bus.cancel_en) begin
      idx = int'((now + SAR) % HZ);
      if (sv[idx]) exp_can = exp_can + 1;
      sv[idx] = 0;
    end
    idx = int'(now % HZ);
    exp_valid = sv[idx];
    exp_type  = sv[idx] ? sty[idx] : 2'd0;
    exp_pay   = sv[idx] ? spay[idx] : '0;
    if (sv[idx]) exp_em = exp_em + 1;
    sv[idx] = 0;
    if (coll) exp_coll = 1;
    now++;
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      check("out_valid", PW'(bus.out_valid), PW'(exp_valid));
      check("out_type", PW'(bus.out_type), PW'(exp_type));
      check("out_payload", bus.out_payload, exp_pay);
      check("collision_err", PW'(bus.collision_err), PW'(exp_coll));
`ifdef TRACE_SEQ_COUNTERS_EN
      check("emitted_count", PW'(bus.emitted_count), PW'(exp_em));
      check("cancelled_count", PW'(bus.cancelled_count), PW'(exp_can));
`endif
      if (bus.out_valid === 1'b1) begin
        seen_pay.push_back(bus.out_payload);
        seen_ty.push_back(bus.out_type);
        seen_edge.push_back(int'(now) - 1);
      end
    end
  end

  task automatic set_idle();
    bus.wb_en = 0; bus.wb_pipe = 0; bus.wb_is_vector = 0; bus.wb_payload = '0;
    bus.st_en = 0; bus.st_payload = '0;
    bus.pcd_en = 0; bus.pcd_late = 0; bus.pcd_payload = '0;
    bus.cancel_en = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    if (!reset) model_edge();
    @(negedge clk);
    #2;
  endtask

  task automatic idle(input int n);
    set_idle();
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    reset = 1;
    model_clear();
    #1;
    check("reset_valid", PW'(bus.out_valid), '0);
    check("reset_coll", PW'(bus.collision_err), '0);
    tick();
    tick();
    reset = 0;
  endtask

  task automatic clear_seen();
    seen_pay.delete(); seen_ty.delete(); seen_edge.delete();
  endtask

  function automatic logic [PW-1:0] rand_pay();
    logic [PW-1:0] p;
    for (int i = 0; i < PW / 32; i++) p[i*32 +: 32] = $urandom;
    return p;
  endfunction

  int t;

  initial begin
    set_idle();
    reset = 1;
    model_clear();
    @(negedge clk);
    #2;
    chk_on = 1;
    tick();
    reset = 0;
    check("reset_state_payload", bus.out_payload, '0);

    // Single-cycle arith writeback lands 4 edges later.
    clear_seen();
    bus.wb_en = 1; bus.wb_pipe = 2; bus.wb_payload = PW'(32'hA5);
    t = int'(now);
    tick();
    idle(6);
    check("t1_count", PW'(seen_pay.size()), PW'(1));
    if (seen_pay.size() == 1) begin
      check("t1_pay", seen_pay[0], PW'(32'hA5));
      check("t1_type", PW'(seen_ty[0]), PW'(1));
      check("t1_edge", PW'(seen_edge[0]), PW'(t + 4));
    end
    check("t1_coll", PW'(bus.collision_err), '0);

    // Reordering of multicycle, mem and store events.
    clear_seen();
    bus.wb_en = 1; bus.wb_pipe = 0; bus.wb_payload = PW'(32'h11);
    bus.st_en = 1; bus.st_payload = PW'(32'h55);
    t = int'(now);
    tick();
    set_idle();
    bus.wb_en = 1; bus.wb_pipe = 1; bus.wb_payload = PW'(32'h33);
    tick();
    idle(7);
    check("t2_count", PW'(seen_pay.size()), PW'(3));
    if (seen_pay.size() == 3) begin
      check("t2_pay0", seen_pay[0], PW'(32'h11));
      check("t2_pay1", seen_pay[1], PW'(32'h33));
      check("t2_pay2", seen_pay[2], PW'(32'h55));
      check("t2_type0", PW'(seen_ty[0]), PW'(1));
      check("t2_type1", PW'(seen_ty[1]), PW'(1));
      check("t2_type2", PW'(seen_ty[2]), PW'(3));
      check("t2_edge1", PW'(seen_edge[1]), PW'(t + 4));
      check("t2_edge2", PW'(seen_edge[2]), PW'(t + 5));
    end

    // Store cancelled as it passes through the arith slot.
    clear_seen();
    bus.st_en = 1; bus.st_payload = PW'(32'h77);
    tick();
    set_idle();
    bus.cancel_en = 1;
    tick();
    idle(8);
    check("t3_count", PW'(seen_pay.size()), '0);
`ifdef TRACE_SEQ_COUNTERS_EN
    check("t3_cancelled", PW'(bus.cancelled_count), PW'(1));
`endif

    // Same-slot collision: writeback beats late PC-destination.
    clear_seen();
    bus.wb_en = 1; bus.wb_pipe = 2; bus.wb_payload = PW'(32'h01);
    bus.pcd_en = 1; bus.pcd_late = 1; bus.pcd_payload = PW'(32'h02);
    t = int'(now);
    tick();
    idle(6);
    check("t4_count", PW'(seen_pay.size()), PW'(1));
    if (seen_pay.size() == 1) begin
      check("t4_pay", seen_pay[0], PW'(32'h01));
      check("t4_edge", PW'(seen_edge[0]), PW'(t + 4));
    end
    check("t4_coll", PW'(bus.collision_err), PW'(1));
    idle(3);
    check("t4_coll_sticky", PW'(bus.collision_err), PW'(1));
    do_reset();
    clear_seen();
    idle(8);
    check("t4_coll_cleared", PW'(bus.collision_err), '0);
    check("t4_empty", PW'(seen_pay.size()), '0);

    // Back-to-back multicycle stream.
    clear_seen();
    for (int i = 0; i < 100; i++) begin
      set_idle();
      bus.wb_en = 1; bus.wb_pipe = 0; bus.wb_payload = PW'(i + 1);
      tick();
    end
    idle(2);
    check("t5_count", PW'(seen_pay.size()), PW'(100));
    for (int i = 0; i < seen_pay.size() && i < 100; i++)
      check("t5_pay", seen_pay[i], PW'(i + 1));
    check("t5_coll", PW'(bus.collision_err), '0);
`ifdef TRACE_SEQ_COUNTERS_EN
    check("t5_emitted", PW'(bus.emitted_count), PW'(100));
`endif

    // Reset while events are in flight.
    clear_seen();
    bus.wb_en = 1; bus.wb_pipe = 2; bus.wb_payload = PW'(32'hB1);
    bus.st_en = 1; bus.st_payload = PW'(32'hB2);
    tick();
    set_idle();
    bus.st_en = 1; bus.st_payload = PW'(32'hB3);
    tick();
    set_idle();
    do_reset();
    idle(10);
    check("t6_empty", PW'(seen_pay.size()), '0);

    // Randomized traffic including reserved pipe and cancels.
    for (int i = 0; i < 600; i++) begin
      set_idle();
      bus.wb_en        = ($urandom_range(0, 99) < 40);
      bus.wb_pipe      = ($urandom_range(0, 19) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      bus.wb_is_vector = $urandom_range(0, 1) == 1;
      bus.wb_payload   = rand_pay();
      bus.st_en        = ($urandom_range(0, 99) < 25);
      bus.st_payload   = rand_pay();
      bus.pcd_en       = ($urandom_range(0, 99) < 15);
      bus.pcd_late     = $urandom_range(0, 1) == 1;
      bus.pcd_payload  = rand_pay();
      bus.cancel_en    = ($urandom_range(0, 99) < 10);
      tick();
      if (i == 300) do_reset();
    end
    idle(8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/trace_event_sequencer.md
Name: trace_event_sequencer

Overview:
Synthesizable reorder queue for cosimulation trace events. Pipelines retire out of order; this block restores issue order.
- Events from the writeback, store and PC-destination paths are placed at fixed slot offsets in a shift queue.
- One event per cycle is drained from slot 0, in issue order.
- It sits between the core's writeback/dcache-tag taps and debug_trace, which consumes the emitted event as capture data.

Parameters:
QUEUE_LEN, 7, number of slots; slot 0 is the output slot.
PAYLOAD_WIDTH, 608, packed event payload bits (pc, thread, reg/addr, mask, data); not interpreted by this block.
SLOT_MULTI, 0, insert slot for multicycle-arithmetic writebacks.
SLOT_MEM, 3, insert slot for memory-pipeline writebacks.
SLOT_ARITH, 4, insert slot for single-cycle-arithmetic writebacks and late PC-destination events.
SLOT_STORE, 5, insert slot for stores and early PC-destination events.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
wb_en  in  1  writeback event valid
wb_pipe  in  2  0=multicycle, 1=mem, 2=single-cycle arith, 3=reserved (ignored, flags error)
wb_is_vector  in  1  1=vector writeback, 0=scalar
wb_payload  in  PAYLOAD_WIDTH  writeback payload
st_en  in  1  store event valid
st_payload  in  PAYLOAD_WIDTH  store payload
pcd_en  in  1  PC-destination event valid
pcd_late  in  1  0=insert at SLOT_STORE, 1=insert at SLOT_ARITH
pcd_payload  in  PAYLOAD_WIDTH  PC-destination payload (typed swriteback)
cancel_en  in  1  invalidate entry landing in SLOT_ARITH this cycle (rollback / failed sync store)
out_valid  out  1  slot 0 holds an event
out_type  out  2  0=invalid, 1=swriteback, 2=vwriteback, 3=store
out_payload  out  PAYLOAD_WIDTH  slot 0 payload
collision_err  out  1  sticky: an insert hit an occupied slot, or wb_pipe==3

Behaviour:
- Reset values: all slots invalid with payload zero; out_valid=0, out_type=0, out_payload=0, collision_err=0. Reset mid-operation discards all queued events.
- Outputs are driven directly from slot-0 registers (registered, no combinational path from inputs).
- Per clock edge, in order:
  1. Shift: slot[i] <= slot[i+1] for i<QUEUE_LEN-1; slot[QUEUE_LEN-1] <= invalid.
  2. Insert into the post-shift slots.
  3. Apply cancel.
- Insert rules:
  - wb_en: target is SLOT_MULTI, SLOT_MEM or SLOT_ARITH per wb_pipe; type is vwriteback if wb_is_vector, else swriteback.
  - st_en: target SLOT_STORE, type store.
  - pcd_en: target SLOT_ARITH if pcd_late, else SLOT_STORE; type swriteback.
- Latency: an event inserted at slot k on edge t is presented on out_* for exactly one cycle, after edge t+k. Slot 0 insertion appears after edge t.
- Collisions:
  - Same-cycle inserts to the same slot: priority wb > pcd > st. The winner is written and collision_err is set.
  - Insert into a post-shift slot already valid: the new event overwrites and collision_err is set.
  - collision_err clears only on reset.
- cancel_en: forces the post-shift SLOT_ARITH entry invalid after inserts. This covers both the entry shifted in from SLOT_ARITH+1 and any same-cycle insert to SLOT_ARITH. Cancel alone never sets collision_err.
- Invalid-slot payloads are don't-care internally, but out_payload must read 0 whenever out_valid=0.
- No backpressure: the consumer must accept every cycle. Events never stall or drop except via cancel or collision overwrite.
- Elaboration checks: every SLOT_* < QUEUE_LEN; QUEUE_LEN >= 2.

Optional Feature:
TRACE_SEQ_COUNTERS_EN
- Defined: adds outputs emitted_count[31:0] and cancelled_count[31:0], both reset to 0.
  - emitted_count increments when out_valid=1 after an edge.
  - cancelled_count increments on each edge where cancel_en invalidates a valid entry.
  - Both wrap from 0xFFFFFFFF to 0.
- Not defined: ports absent, no counter logic.

Test Plan:
- Reset, then wb_en with pipe=2, scalar, payload 0xA5 at edge t -> out_valid=1, type=1, payload 0xA5 after edge t+4 only; collision_err=0.
- Same edge: wb pipe=0 (0x11) and st_en (0x55); next edge wb pipe=1 (0x33) -> output order 0x11 (t), 0x33 (t+4), 0x55 (t+5), with types 1, 1, 3.
- st_en 0x77 at edge t, cancel_en at edge t+1 -> 0x77 never emitted; out_valid stays 0 for 8 cycles; with TRACE_SEQ_COUNTERS_EN, cancelled_count=1.
- wb pipe=2 (0x01) and pcd_en late (0x02) on same edge -> 0x01 emitted at t+4 and collision_err=1 sticky. After reset, collision_err=0 and the queue is empty.
- Stream wb pipe=0 scalar every cycle for 100 cycles with incrementing payload -> 100 consecutive outputs in order; no collision. With counters, emitted_count=100.
- Assert reset while 3 events are queued -> out_valid=0 during and after reset; no queued event emerges afterward.
